// File: rtl/bottle_line_emulator.sv
// bottle_line_emulator: closed-loop stand-in for the physical bottling line.
// Turns the controller's motor/valve/discard commands into tick-timed garrafa/cheia/QC sensor levels.
module bottle_line_emulator #(
    parameter int TRAVEL_TICKS   = 8,
    parameter int FILL_TICKS     = 5,
    parameter int OVERFILL_TICKS = 3,
    parameter int QC_TICKS       = 3,
    parameter int REJECT_PERIOD  = 4,
    parameter int SUPPLY         = 24
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       motor,
    input  logic       valvula,
    input  logic       descartado,
    input  logic       supply_load,
    output logic       garrafa,
    output logic       cheia,
    output logic       aprovado,
    output logic       reprovado,
    output logic       supply_empty,
    output logic [7:0] bottles_out,
    output logic [7:0] discards,
    output logic       fault
);

    localparam logic [7:0] TRAVEL_T   = 8'(TRAVEL_TICKS);
    localparam logic [7:0] FILL_T     = 8'(FILL_TICKS);
    localparam logic [7:0] OVERFILL_T = 8'(OVERFILL_TICKS);
    localparam logic [7:0] QC_T       = 8'(QC_TICKS);
    localparam logic [7:0] SUPPLY_V   = 8'(SUPPLY);
    localparam logic       REJECT_EN  = (REJECT_PERIOD > 32'sd0);
    // A zero period never rejects; the divisor is kept non-zero so the modulo stays well defined.
    localparam logic [8:0] REJECT_DIV = REJECT_EN ? 9'(REJECT_PERIOD) : 9'd1;

    typedef enum logic [2:0] {
        st_travel   = 3'd0,
        st_at_valve = 3'd1,
        st_full     = 3'd2,
        st_qc       = 3'd3,
        st_empty    = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_nx_s;
    logic [7:0] pos_r;
    logic [7:0] pos_nx_s;
    logic [7:0] pos_inc_s;
    logic       pos_adv_s;
    logic [7:0] supply_r;
    logic [7:0] supply_nx_s;
    logic [7:0] bottles_out_r;
    logic [7:0] bottles_out_nx_s;
    logic [7:0] discards_r;
    logic [7:0] discards_nx_s;
    logic       fail_r;
    logic       fail_nx_s;
    logic       disc_done_r;
    logic       disc_done_nx_s;
    logic       fault_r;
    logic       fault_nx_s;
    logic       garrafa_r;
    logic       garrafa_nx_s;
    logic       cheia_r;
    logic       cheia_nx_s;
    logic       aprovado_r;
    logic       aprovado_nx_s;
    logic       reprovado_r;
    logic       reprovado_nx_s;
    logic       supply_empty_r;
    logic       supply_empty_nx_s;
    logic [8:0] bottle_idx_s;
    logic       qc_entry_s;
    logic       qc_exit_s;
    logic       arrive_s;
    logic       discard_s;
    logic       stray_valve_s;
    logic       overfill_s;

    function automatic logic is_reject(input logic [8:0] idx);
        is_reject = REJECT_EN && ((idx % REJECT_DIV) == 9'd0);
    endfunction

    assign pos_inc_s = (pos_r == 8'hFF) ? pos_r : (pos_r + 8'd1);

    // Next-state logic and position counter advance.
    always_comb begin
        state_nx_s = state_r;
        pos_adv_s  = 1'b0;
        case (state_r)
            st_travel: begin
                if (tick_en && motor) begin
                    if (pos_inc_s == TRAVEL_T) begin
                        state_nx_s = st_at_valve;
                    end else begin
                        pos_adv_s = 1'b1;
                    end
                end else begin
                    pos_adv_s = 1'b0;
                end
            end
            st_at_valve: begin
                if (tick_en && motor) begin
                    state_nx_s = st_qc;
                end else if (tick_en && valvula) begin
                    if (pos_inc_s == FILL_T) begin
                        state_nx_s = st_full;
                    end else begin
                        pos_adv_s = 1'b1;
                    end
                end else begin
                    pos_adv_s = 1'b0;
                end
            end
            st_full: begin
                if (tick_en && motor) begin
                    state_nx_s = st_qc;
                end else if (tick_en && valvula) begin
                    pos_adv_s = 1'b1;
                end else begin
                    pos_adv_s = 1'b0;
                end
            end
            st_qc: begin
                if (tick_en) begin
                    if (pos_inc_s == QC_T) begin
                        state_nx_s = ((supply_r != 8'd0) || supply_load) ? st_travel : st_empty;
                    end else begin
                        pos_adv_s = 1'b1;
                    end
                end else begin
                    pos_adv_s = 1'b0;
                end
            end
            st_empty: begin
                if (supply_load) begin
                    state_nx_s = st_travel;
                end else begin
                    state_nx_s = st_empty;
                end
            end
            default: begin
                state_nx_s = st_travel;
            end
        endcase
        pos_nx_s = (state_nx_s != state_r) ? 8'd0 : (pos_adv_s ? pos_inc_s : pos_r);
    end

    // Next values of counters, QC verdict and the registered sensor outputs.
    always_comb begin
        qc_entry_s    = (state_r != st_qc) && (state_nx_s == st_qc);
        qc_exit_s     = (state_r == st_qc) && (state_nx_s != st_qc);
        arrive_s      = (state_r == st_travel) && (state_nx_s == st_at_valve);
        bottle_idx_s  = {1'b0, bottles_out_r} + 9'd1;
        stray_valve_s = tick_en && valvula &&
                        ((state_r == st_travel) || (state_r == st_qc) || (state_r == st_empty));
        // Valve still open while the full bottle is pushed out counts as overflow too.
        overfill_s    = (state_r == st_full) && tick_en && valvula &&
                        (motor || (pos_inc_s >= OVERFILL_T));
        discard_s     = (state_r == st_qc) && descartado && reprovado_r && !disc_done_r;

        if (qc_entry_s) begin
            fail_nx_s      = (state_r == st_at_valve) || is_reject(bottle_idx_s);
            disc_done_nx_s = 1'b0;
        end else begin
            fail_nx_s      = fail_r;
            disc_done_nx_s = disc_done_r | discard_s;
        end

        if (supply_load) begin
            supply_nx_s = SUPPLY_V;
        end else if (arrive_s && (supply_r != 8'd0)) begin
            supply_nx_s = supply_r - 8'd1;
        end else begin
            supply_nx_s = supply_r;
        end

        bottles_out_nx_s  = qc_exit_s ? (bottles_out_r + 8'd1) : bottles_out_r;
        discards_nx_s     = discard_s ? (discards_r + 8'd1) : discards_r;
        fault_nx_s        = fault_r | stray_valve_s | overfill_s;
        garrafa_nx_s      = (state_nx_s == st_at_valve) || (state_nx_s == st_full);
        cheia_nx_s        = (state_nx_s == st_full);
        aprovado_nx_s     = (state_nx_s == st_qc) && !fail_nx_s;
        reprovado_nx_s    = (state_nx_s == st_qc) && fail_nx_s;
        supply_empty_nx_s = (state_nx_s == st_empty);
    end

    // State, counters and output registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r        <= st_travel;
            pos_r          <= 8'd0;
            supply_r       <= SUPPLY_V;
            bottles_out_r  <= 8'd0;
            discards_r     <= 8'd0;
            fail_r         <= 1'b0;
            disc_done_r    <= 1'b0;
            fault_r        <= 1'b0;
            garrafa_r      <= 1'b0;
            cheia_r        <= 1'b0;
            aprovado_r     <= 1'b0;
            reprovado_r    <= 1'b0;
            supply_empty_r <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            pos_r          <= pos_nx_s;
            supply_r       <= supply_nx_s;
            bottles_out_r  <= bottles_out_nx_s;
            discards_r     <= discards_nx_s;
            fail_r         <= fail_nx_s;
            disc_done_r    <= disc_done_nx_s;
            fault_r        <= fault_nx_s;
            garrafa_r      <= garrafa_nx_s;
            cheia_r        <= cheia_nx_s;
            aprovado_r     <= aprovado_nx_s;
            reprovado_r    <= reprovado_nx_s;
            supply_empty_r <= supply_empty_nx_s;
        end
    end

    assign garrafa      = garrafa_r;
    assign cheia        = cheia_r;
    assign aprovado     = aprovado_r;
    assign reprovado    = reprovado_r;
    assign supply_empty = supply_empty_r;
    assign bottles_out  = bottles_out_r;
    assign discards     = discards_r;
    assign fault        = fault_r;

endmodule

// File: tb/tb_bottle_line_emulator.sv
// Bench for bottle_line_emulator: a bottle-journey model checked every cycle, plus directed
// scenarios with literal timing/count expectations (travel, fill, overfill, QC, discards, empty, reset).
module tb_bottle_line_emulator;

    localparam int TRAVEL = 8;
    localparam int FILL   = 5;
    localparam int OVER   = 3;
    localparam int QCT    = 3;
    localparam int RP     = 4;
    localparam int SUP    = 24;

    localparam int P_FEED  = 0;
    localparam int P_VALVE = 1;
    localparam int P_FULL  = 2;
    localparam int P_QC    = 3;
    localparam int P_EMPTY = 4;

    logic       CLK = 1'b0;
    logic       reset;
    logic       tick_en;
    logic       motor;
    logic       valvula;
    logic       descartado;
    logic       supply_load;
    logic       garrafa;
    logic       cheia;
    logic       aprovado;
    logic       reprovado;
    logic       supply_empty;
    logic [7:0] bottles_out;
    logic [7:0] discards;
    logic       fault;

    int checks = 0;
    int errors = 0;

    int m_where = 0;
    int m_ticks = 0;
    int m_supply = 0;
    int m_out = 0;
    int m_disc = 0;
    bit m_fault = 1'b0;
    bit m_fail = 1'b0;
    bit m_counted = 1'b0;
    bit m_valid = 1'b0;

    bottle_line_emulator #(
        .TRAVEL_TICKS(TRAVEL), .FILL_TICKS(FILL), .OVERFILL_TICKS(OVER),
        .QC_TICKS(QCT), .REJECT_PERIOD(RP), .SUPPLY(SUP)
    ) dut (
        .CLK(CLK), .reset(reset), .tick_en(tick_en), .motor(motor), .valvula(valvula),
        .descartado(descartado), .supply_load(supply_load), .garrafa(garrafa), .cheia(cheia),
        .aprovado(aprovado), .reprovado(reprovado), .supply_empty(supply_empty),
        .bottles_out(bottles_out), .discards(discards), .fault(fault)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Where the current bottle is and what the line has done, advanced once per clock.
    task automatic model_step();
        int  w = m_where;
        int  t = m_ticks;
        int  s = m_supply;
        int  o = m_out;
        int  d = m_disc;
        bit  f = m_fault;
        bit  fl = m_fail;
        bit  c = m_counted;
        bit  to_qc = 1'b0;
        bit  unfilled = 1'b0;
        if (reset) begin
            w = P_FEED; t = 0; s = SUP; o = 0; d = 0; f = 1'b0; fl = 1'b0; c = 1'b0;
        end else begin
            if (w == P_QC && fl && descartado && !c) begin
                d = (d + 1) % 256;
                c = 1'b1;
            end
            if (tick_en && valvula && (w == P_FEED || w == P_QC || w == P_EMPTY)) f = 1'b1;
            if (w == P_FEED) begin
                if (tick_en && motor) begin
                    t++;
                    if (t == TRAVEL) begin w = P_VALVE; t = 0; s = s - 1; end
                end
            end else if (w == P_VALVE) begin
                if (tick_en && motor) begin
                    to_qc = 1'b1; unfilled = 1'b1;
                end else if (tick_en && valvula) begin
                    t++;
                    if (t == FILL) begin w = P_FULL; t = 0; end
                end
            end else if (w == P_FULL) begin
                if (tick_en && motor) begin
                    if (valvula) f = 1'b1;
                    to_qc = 1'b1;
                end else if (tick_en && valvula) begin
                    t++;
                    if (t >= OVER) f = 1'b1;
                end
            end else if (w == P_QC) begin
                if (tick_en) begin
                    t++;
                    if (t == QCT) begin
                        o = (o + 1) % 256;
                        w = (s > 0 || supply_load) ? P_FEED : P_EMPTY;
                        t = 0;
                    end
                end
            end else begin
                if (supply_load) begin w = P_FEED; t = 0; end
            end
            if (to_qc) begin
                w = P_QC; t = 0; c = 1'b0;
                fl = unfilled || (RP != 0 && ((o + 1) % RP) == 0);
            end
            if (supply_load) s = SUP;
        end
        m_where <= w; m_ticks <= t; m_supply <= s; m_out <= o; m_disc <= d;
        m_fault <= f; m_fail <= fl; m_counted <= c; m_valid <= m_valid | reset;
    endtask

    always @(posedge CLK) model_step();

    // Compare every DUT output against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            chk("garrafa", int'(garrafa), int'(m_where == P_VALVE || m_where == P_FULL));
            chk("cheia", int'(cheia), int'(m_where == P_FULL));
            chk("aprovado", int'(aprovado), int'(m_where == P_QC && !m_fail));
            chk("reprovado", int'(reprovado), int'(m_where == P_QC && m_fail));
            chk("supply_empty", int'(supply_empty), int'(m_where == P_EMPTY));
            chk("bottles_out", int'(bottles_out), m_out);
            chk("discards", int'(discards), m_disc);
            chk("fault", int'(fault), int'(m_fault));
        end
    end

    function automatic bit probe(input int sel);
        case (sel)
            0: return garrafa;
            1: return cheia;
            2: return fault;
            3: return aprovado | reprovado;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag, output int n);
        bit seen = 1'b0;
        n = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge CLK);
            n++;
            seen = probe(sel);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=not-seen required=seen", tag);
        end
    endtask

    task automatic travel_bottle(input string tag);
        int n;
        motor = 1'b1;
        wait_for(0, {tag, " travel"}, n);
        chk({tag, " travel ticks"}, n, 8);
    endtask

    task automatic fill_bottle(input string tag);
        int n;
        motor = 1'b0;
        valvula = 1'b1;
        wait_for(1, {tag, " fill"}, n);
        chk({tag, " fill ticks"}, n, 5);
    endtask

    task automatic do_qc(input int pulses, input bit exp_fail, input string tag);
        int n;
        int hold = 0;
        bit done = 1'b0;
        valvula = 1'b0;
        motor = 1'b1;
        wait_for(3, {tag, " qc"}, n);
        chk({tag, " qc latency"}, n, 1);
        chk({tag, " reprovado"}, int'(reprovado), int'(exp_fail));
        for (int i = 0; i < 16 && !done; i++) begin
            if (!(aprovado || reprovado)) begin
                done = 1'b1;
            end else begin
                hold++;
                descartado = ((pulses >= 1) && (hold == 1)) || ((pulses >= 2) && (hold == 3));
                @(negedge CLK);
            end
        end
        descartado = 1'b0;
        motor = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s hold timeout actual=stuck required=release", tag);
        end
        chk({tag, " qc hold"}, hold, 3);
    endtask

    task automatic run_bottle(input int pulses, input bit exp_fail, input string tag);
        travel_bottle(tag);
        fill_bottle(tag);
        do_qc(pulses, exp_fail, tag);
    endtask

    initial begin
        int n;
        reset = 1'b1; tick_en = 1'b1; motor = 1'b0; valvula = 1'b0;
        descartado = 1'b0; supply_load = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset garrafa", int'(garrafa), 0);
        chk("reset bottles_out", int'(bottles_out), 0);
        chk("reset fault", int'(fault), 0);
        chk("reset supply_empty", int'(supply_empty), 0);
        reset = 1'b0;

        // Bottles 1-4: bottle 2 gets a stray discard, bottle 4 fails and is discarded twice.
        for (int b = 1; b <= 4; b++)
            run_bottle((b == 2) ? 1 : ((b == 4) ? 2 : 0), (b == 4), $sformatf("b%0d", b));
        chk("bottles_out after 4", int'(bottles_out), 4);
        chk("discards after 4", int'(discards), 1);

        // Bottle 5: conveyor paused 4 ticks mid-travel.
        motor = 1'b1;
        repeat (4) @(negedge CLK);
        motor = 1'b0;
        repeat (4) @(negedge CLK);
        motor = 1'b1;
        wait_for(0, "b5 travel", n);
        chk("b5 elapsed ticks", 8 + n, 12);
        fill_bottle("b5");
        do_qc(0, 1'b0, "b5");

        // Bottle 6: valve held past full until overflow.
        travel_bottle("b6");
        fill_bottle("b6");
        wait_for(2, "b6 overflow", n);
        chk("b6 overflow ticks", n, 3);
        do_qc(0, 1'b0, "b6");
        chk("fault sticky", int'(fault), 1);

        for (int b = 7; b <= 24; b++)
            run_bottle(0, (b % 4) == 0, $sformatf("b%0d", b));
        chk("empty flag", int'(supply_empty), 1);
        chk("bottles_out at empty", int'(bottles_out), 24);
        chk("discards at empty", int'(discards), 1);

        motor = 1'b1;
        repeat (5) @(negedge CLK);
        chk("empty garrafa idle", int'(garrafa), 0);
        chk("empty holds", int'(supply_empty), 1);
        motor = 1'b0;
        supply_load = 1'b1;
        @(negedge CLK);
        supply_load = 1'b0;
        chk("reload clears empty", int'(supply_empty), 0);
        run_bottle(0, 1'b0, "b25");
        chk("bottles_out after reload", int'(bottles_out), 25);

        // Reset (with a simultaneous reload request) while a bottle is full.
        travel_bottle("r1");
        fill_bottle("r1");
        valvula = 1'b0;
        reset = 1'b1;
        supply_load = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        supply_load = 1'b0;
        chk("mid reset garrafa", int'(garrafa), 0);
        chk("mid reset cheia", int'(cheia), 0);
        chk("mid reset bottles_out", int'(bottles_out), 0);
        chk("mid reset discards", int'(discards), 0);
        chk("mid reset fault", int'(fault), 0);

        // Bottle pushed out half-filled fails QC even though index 1 would pass.
        travel_bottle("u1");
        motor = 1'b0;
        valvula = 1'b1;
        repeat (2) @(negedge CLK);
        do_qc(1, 1'b1, "u1");
        chk("unfilled discards", int'(discards), 1);
        chk("unfilled bottles_out", int'(bottles_out), 1);

        // Valve opened with no bottle under it.
        valvula = 1'b1;
        @(negedge CLK);
        valvula = 1'b0;
        chk("stray valve fault", int'(fault), 1);
        repeat (2) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bottle_line_emulator.md
Name: bottle_line_emulator

Overview:
- Closed-loop model of the bottling line, sitting on the opposite side of the sensor/actuator interface from the line controller.
- Consumes the controller's actuator outputs (motor, valvula, descartado).
- Produces the sensor inputs the controller expects (garrafa, cheia, aprovado, reprovado), with tick-based conveyor, fill and quality-check timing.
- Used for board-level demo without a physical conveyor and as the reference stimulus for controller regression.

Parameters:
- TRAVEL_TICKS, 8, motor-on ticks for a bottle to travel from feed to under the valve.
- FILL_TICKS, 5, valve-open ticks needed to fill a bottle.
- OVERFILL_TICKS, 3, extra valve-open ticks after full before the overflow fault.
- QC_TICKS, 3, ticks the quality result is held at the QC station.
- REJECT_PERIOD, 4, every Nth bottle fails QC; 0 means no bottle ever fails.
- SUPPLY, 24, bottles loaded into the feed by reset or supply_load; range 1..255.

Ports:
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high
- tick_en  in  1  one-cycle time-base strobe; all timers advance only on cycles with tick_en=1
- motor  in  1  conveyor running (from controller)
- valvula  in  1  fill valve open (from controller)
- descartado  in  1  controller discard actuator
- supply_load  in  1  reload feed to SUPPLY bottles
- garrafa  out  1  bottle present under valve
- cheia  out  1  bottle under valve is full
- aprovado  out  1  QC pass, level signal
- reprovado  out  1  QC fail, level signal
- supply_empty  out  1  feed exhausted
- bottles_out  out  8  bottles that left the QC station
- discards  out  8  failed bottles discarded by the controller
- fault  out  1  sticky: valve opened with no bottle present, or overflow

Behaviour:
- Reset (synchronous, CLK rising edge with reset=1) values:
  - state=TRAVEL, supply=SUPPLY.
  - All counters = 0.
  - garrafa, cheia, aprovado, reprovado, supply_empty, fault = 0.
- All outputs are registered. A state change is visible on the outputs the cycle after the qualifying tick_en cycle.
- Position counter: counts ticks in the current state. It clears on every state change.
- TRAVEL:
  - Counter increments on tick_en & motor; it holds while motor=0.
  - When the counter reaches TRAVEL_TICKS: go to AT_VALVE, decrement supply, garrafa<=1.
- AT_VALVE:
  - Counter increments on tick_en & valvula.
  - When the counter reaches FILL_TICKS: go to FULL, cheia<=1.
  - If motor=1 before full: bottle leaves unfilled. garrafa<=0, go to QC, result forced to fail.
- FULL:
  - Counter increments on tick_en & valvula.
  - When the counter reaches OVERFILL_TICKS: fault<=1. State is unchanged.
  - If motor=1 with valvula=0: garrafa<=0, cheia<=0, go to QC.
  - If motor and valvula are both 1: the bottle still leaves, and fault<=1.
- QC:
  - Entry sets the bottle index n = bottles_out+1.
  - Fail if REJECT_PERIOD≠0 and n mod REJECT_PERIOD = 0, or if the bottle is unfilled.
  - reprovado<=fail; aprovado<=~fail.
  - Counter increments on tick_en only (independent of motor).
  - At QC_TICKS: aprovado and reprovado return to 0, bottles_out increments (wraps 255→0). If supply>0 go to TRAVEL, else go to EMPTY.
- Discards: descartado=1 during QC with reprovado=1 increments discards once per bottle. A second assertion in the same QC visit is ignored. descartado at any other time is ignored.
- EMPTY:
  - supply_empty=1; all sensor outputs are 0.
  - supply_load moves the model to TRAVEL with supply=SUPPLY and supply_empty<=0.
  - supply_load in any other state only reloads supply.
- Fault: valvula=1 on a tick_en cycle in TRAVEL, QC or EMPTY sets fault. fault clears only on reset.
- Invariants:
  - aprovado and reprovado are never both 1.
  - cheia=1 implies garrafa=1.
- Reset mid-operation aborts the bottle in progress; it is not counted in bottles_out.
- Simultaneous reset and supply_load: reset wins.

Test Plan:
- Defaults, tick_en every cycle, motor=1 until garrafa, then valvula=1 until cheia, then valvula=0, motor=1 → garrafa after 8 ticks, cheia after 5 ticks; bottles 1–3 produce aprovado, bottle 4 produces reprovado, each held 3 ticks; bottles_out=4.
- motor=0 for 4 ticks mid-TRAVEL → position holds; garrafa rises after 8 motor-on ticks total (12 elapsed ticks).
- valvula held 5+3 ticks at the valve → cheia at tick 5, fault=1 at tick 8; fault stays 1 until reset.
- descartado pulsed twice during reprovado on bottle 4 → discards=1; descartado during an aprovado bottle → discards unchanged.
- SUPPLY=2, run two full cycles → supply_empty=1, outputs idle; pulse supply_load → supply_empty=0, travel restarts.
- reset asserted while cheia=1 → next cycle all outputs 0, bottles_out=0, state TRAVEL.
